// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared opcode/state encodings and helpers for the EX-stage mult/div unit
package ex_muldiv_pkg;

    // Register-file data width; the iteration count of the unit equals this.
    localparam int REG_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    // op[1] selects divide, op[0] selects the unsigned variant.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - EX-stage request/result bundle between the pipeline and the mult/div unit
// master: pipeline side (drives start/op/src_a/src_b/flush, receives results and stall request)
// slave : mult/div unit side
interface ex_muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  flush;
    logic                  stall_req;
    logic                  done;
    logic                  div_by_zero;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;

    modport master (
        output start, op, src_a, src_b, flush,
        input  stall_req, done, div_by_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output stall_req, done, div_by_zero, hi_out, lo_out
    );
endinterface

// File: rtl/ex_muldiv_datapath.sv
// rtl/ex_muldiv_datapath.sv - shift registers and adder/subtractor, one mult/div iteration per step
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            initialise: hi=0, lo=init_lo, operand=init_opnd
//   step            perform one iteration (shift-add or restoring-divide)
//   is_div          iteration kind for the operation in flight
//   init_lo         multiplier (mult) or dividend (div), already made unsigned
//   init_opnd       multiplicand (mult) or divisor (div), already made unsigned
//   hi, lo          product[63:32]/[31:0] or remainder/quotient after DATA_WIDTH steps
module ex_muldiv_datapath
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] init_lo,
    input  logic [DATA_WIDTH-1:0] init_opnd,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [DATA_WIDTH-1:0] opnd_q;

    logic [DATA_WIDTH:0]   add_sum;
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH+1:0] rem_diff;
    logic [DATA_WIDTH-1:0] hi_next;
    logic [DATA_WIDTH-1:0] lo_next;
    logic                  unused_diff_bit;

    always_comb begin
        // Multiply: {hi,lo} is the running product, lo[0] is the current multiplier bit.
        add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(DATA_WIDTH+1){1'b0}});
        // Divide: partial remainder shifted left, pulling in the next dividend bit from lo.
        // The remainder is below the divisor, so the shifted value fits in DATA_WIDTH+1 bits
        // and a trial subtraction that does not borrow always fits back in DATA_WIDTH bits.
        rem_shift = {hi_q, lo_q[DATA_WIDTH-1]};
        rem_diff  = {1'b0, rem_shift} - {2'b00, opnd_q};

        hi_next = hi_q;
        lo_next = lo_q;
        if (is_div) begin
            if (!rem_diff[DATA_WIDTH+1]) begin
                hi_next = rem_diff[DATA_WIDTH-1:0];
                lo_next = {lo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                hi_next = rem_shift[DATA_WIDTH-1:0];
                lo_next = {lo_q[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next = add_sum[DATA_WIDTH:1];
            lo_next = {add_sum[0], lo_q[DATA_WIDTH-1:1]};
        end
    end

    assign unused_diff_bit = rem_diff[DATA_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else if (load) begin
            hi_q   <= '0;
            lo_q   <= init_lo;
            opnd_q <= init_opnd;
        end else if (step) begin
            hi_q   <= hi_next;
            lo_q   <= lo_next;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit in EX with pipeline stall request
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   bus (slave)     start/op/src_a/src_b/flush in; stall_req (combinational), done pulse,
//                   div_by_zero, hi_out/lo_out (registered, change only on completion) out
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

    muldiv_state_e state_q, state_d;
    muldiv_op_e    op_q;
    logic          sign_a_q;
    logic          sign_b_q;
    logic          dz_q;
    logic [CW-1:0] count_q;

    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic                  done_q;
    logic                  dz_out_q;

    logic                  accept;
    logic                  load;
    logic                  step;
    logic                  commit;
    logic                  stall_req;

    logic                  new_div;
    logic                  new_signed;
    logic                  new_sign_a;
    logic                  new_sign_b;
    logic                  new_dz;
    logic [DATA_WIDTH-1:0] abs_a;
    logic [DATA_WIDTH-1:0] abs_b;
    logic [DATA_WIDTH-1:0] init_lo;
    logic [DATA_WIDTH-1:0] init_opnd;

    logic [DATA_WIDTH-1:0]   dp_hi;
    logic [DATA_WIDTH-1:0]   dp_lo;
    logic [2*DATA_WIDTH-1:0] product;
    logic                    neg_res;
    logic [DATA_WIDTH-1:0]   res_hi;
    logic [DATA_WIDTH-1:0]   res_lo;

    // Operand preparation for a newly accepted instruction. The negation of the most
    // negative value wraps to itself, which read as unsigned is exactly its magnitude.
    always_comb begin
        new_div    = op_is_div(bus.op);
        new_signed = op_is_signed(bus.op);
        new_sign_a = new_signed & bus.src_a[DATA_WIDTH-1];
        new_sign_b = new_signed & bus.src_b[DATA_WIDTH-1];
        new_dz     = new_div && (bus.src_b == '0);
        // On divide-by-zero the raw dividend is kept so it can be returned untouched in hi.
        abs_a      = (new_sign_a && !new_dz) ? -bus.src_a : bus.src_a;
        abs_b      = new_sign_b ? -bus.src_b : bus.src_b;
        init_lo    = new_div ? abs_a : abs_b;
        init_opnd  = new_div ? abs_b : abs_a;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        stall_req = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    accept    = 1'b1;
                    load      = 1'b1;
                    stall_req = 1'b1;
                    state_d   = new_dz ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                stall_req = 1'b1;
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (count_q == LAST_ITER) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // The instruction leaves EX at the end of this cycle; start is not
                // looked at here so the same instruction cannot be accepted twice.
                commit  = !bus.flush;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    ex_muldiv_datapath #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .is_div    (op_is_div(op_q)),
        .init_lo   (init_lo),
        .init_opnd (init_opnd),
        .hi        (dp_hi),
        .lo        (dp_lo)
    );

    // Sign correction of the unsigned magnitude result. Sign flags are zero for the
    // unsigned ops, so no op check is needed here.
    always_comb begin
        product = {dp_hi, dp_lo};
        neg_res = sign_a_q ^ sign_b_q;
        res_hi  = dp_hi;
        res_lo  = dp_lo;
        if (dz_q) begin
            res_hi = dp_lo;
            res_lo = '1;
        end else if (op_is_div(op_q)) begin
            res_lo = neg_res  ? -dp_lo : dp_lo;
            res_hi = sign_a_q ? -dp_hi : dp_hi;
        end else if (neg_res) begin
            {res_hi, res_lo} = -product;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= muldiv_op_e'(bus.op);
                sign_a_q <= new_sign_a;
                sign_b_q <= new_sign_b;
                dz_q     <= new_dz;
            end
            if (load) begin
                count_q <= '0;
            end else if (step) begin
                count_q <= count_q + 1'b1;
            end
            done_q   <= commit;
            dz_out_q <= commit & dz_q;
            if (commit) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    assign bus.stall_req   = stall_req;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_out_q;
    assign bus.hi_out      = hi_q;
    assign bus.lo_out      = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv with a reference arithmetic model
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if #(.DATA_WIDTH(W)) bus ();

    ex_muldiv #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] held_hi;
    logic [31:0] held_lo;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain-arithmetic reference: 64-bit signed/unsigned product, truncating division.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        case (op)
            2'b00: begin
                p    = sa * sbv;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p    = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.dz = 1'b1;
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    q    = sa / sbv;
                    r    = sa % sbv;
                    e.hi = r[31:0];
                    e.lo = q[31:0];
                end else begin
                    e.hi = a % b;
                    e.lo = a / b;
                end
            end
        endcase
        return e;
    endfunction

    // Acts as the ID/EX register: the instruction stays in EX while stall_req is high
    // and moves on at the first edge where it is low. Called and returns at a negedge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name);
        exp_t e;
        int   stalls;
        stalls = 0;
        e      = model(op, a, b);
        e.name = name;
        e.cyc  = cyc + (e.dz ? 2 : W + 2);
        sb.push_back(e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.flush = 1'b0;
        #1;
        while (bus.stall_req && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check({name, " stall cycles"}, 64'(stalls), 64'(e.dz ? 1 : W + 1));
        @(negedge clk);
    endtask

    task automatic bubble(input int n);
        bus.start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corner [5];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 300));
        return 32'($urandom);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation, at the
    // expected cycle; between pulses the result registers must hold.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_hi <= '0;
            held_lo <= '0;
        end else if (bus.done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected done at cycle %0d: got done=1, expected 0", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, " hi"}, 64'(bus.hi_out), 64'(e.hi));
                check({e.name, " lo"}, 64'(bus.lo_out), 64'(e.lo));
                check({e.name, " div_by_zero"}, 64'(bus.div_by_zero), 64'(e.dz));
                check({e.name, " done cycle"}, 64'(cyc), 64'(e.cyc));
                held_hi <= e.hi;
                held_lo <= e.lo;
            end
        end else begin
            check("hold hi", 64'(bus.hi_out), 64'(held_hi));
            check("hold lo", 64'(bus.lo_out), 64'(held_lo));
            check("div_by_zero without done", 64'(bus.div_by_zero), 64'd0);
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, " hi_out"}, 64'(bus.hi_out), 64'd0);
        check({tag, " lo_out"}, 64'(bus.lo_out), 64'd0);
        check({tag, " done"}, 64'(bus.done), 64'd0);
        check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'd0);
        check({tag, " stall_req"}, 64'(bus.stall_req), 64'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.flush = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        bubble(2);
        issue(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, "mult_neg2x3");
        issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
        issue(OP_DIVU,  32'd100,       32'd7,         "divu_100_7");
        issue(OP_DIVU,  32'd5,         32'd0,         "divu_by_zero");
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd0,         "div_by_zero_neg");
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        issue(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin");
        issue(OP_DIV,   32'd7,         32'hFFFF_FFFE, "div_7_m2");
        bubble(1);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            issue(op, a, b, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) bubble($urandom_range(1, 3));
        end

        issue(OP_DIVU, 32'd100, 32'd7, "divu_before_flush");
        bubble(2);

        // flush has priority over start while idle
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        bus.flush = 1'b1;
        #1;
        check("flush over start stall_req", 64'(bus.stall_req), 64'd0);
        @(negedge clk);

        // flush at CALC iteration 10
        bus.flush = 1'b0;
        @(negedge clk);
        repeat (10) @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b1;
        #1;
        check("calc stall_req before flush", 64'(bus.stall_req), 64'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("stall_req after flush", 64'(bus.stall_req), 64'd0);
        repeat (40) @(negedge clk);

        // asynchronous reset in the middle of CALC
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.src_a = 32'd12345;
        bus.src_b = 32'd678;
        @(negedge clk);
        repeat (5) @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b1;
        #1;
        check_outputs_zero("mid-calc reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(OP_MULTU, 32'd12345, 32'd678, "after_reset");
        bubble(1);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL outstanding results: got %0d pending, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the EX-stage operands and executes MULT/MULTU/DIV/DIVU over multiple cycles.
- While busy it raises a stall request that drives the is_hold input of the upstream pipeline registers.
- On completion it presents a 64-bit result as hi/lo with a one-cycle write pulse for the HI/LO register file.

Parameters:
- DATA_WIDTH, 32, operand width (equals `RegDataWidth); the iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  valid mult/div instruction is present in EX.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  DATA_WIDTH  rs operand (dividend / multiplicand), after forwarding.
- src_b  in  DATA_WIDTH  rt operand (divisor / multiplier), after forwarding.
- flush  in  1  synchronous abort of the current operation.
- stall_req  out  1  hold request to the IF/ID and ID/EX registers.
- done  out  1  one-cycle pulse: hi_out/lo_out are valid and must be written.
- div_by_zero  out  1  asserted together with done when a DIV/DIVU divisor was 0.
- hi_out  out  DATA_WIDTH  product[63:32] or remainder.
- lo_out  out  DATA_WIDTH  product[31:0] or quotient.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, counter=0.
  - hi_out=0, lo_out=0, done=0, div_by_zero=0.
  - stall_req evaluates to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - When start=1 and flush=0: latch op and the sign flags; latch |src_a| and |src_b| for signed ops, raw values for unsigned ops. Clear the counter and the partial result, then go to CALC.
  - For DIV/DIVU with src_b==0: go directly to DONE with the div_by_zero flag set.
- CALC:
  - One iteration per cycle.
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle.
  - After iteration counter==DATA_WIDTH-1, go to DONE. CALC always lasts exactly DATA_WIDTH cycles.
- DONE:
  - Apply sign correction. Signed product is negated when sign_a^sign_b. Signed quotient is negated when sign_a^sign_b. Signed remainder takes the sign of the dividend.
  - Register hi_out/lo_out, pulse done=1 for this cycle only, then go to IDLE.
- stall_req = (state==IDLE && start && !flush) || state==CALC. This signal is combinational.
  - In DONE stall_req=0, so the mult/div instruction leaves EX at the end of the DONE cycle.
  - start is ignored in DONE, so the same instruction never restarts.
- Latency: with start sampled at edge k, done is high in the cycle after edge k+1+DATA_WIDTH (33 cycles of stall for 32-bit). The divide-by-zero path gives done one cycle after acceptance.
- Divide by zero result: lo_out=all ones, hi_out=src_a (raw), div_by_zero=1 with done.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- MULT 0x80000000 * 0x80000000 gives hi=0x40000000, lo=0. The absolute value of 0x80000000 is taken as unsigned 0x80000000.
- Flush:
  - In CALC or DONE: go to IDLE on the next edge. No done pulse; hi_out/lo_out keep their previous values.
  - flush has priority over start.
- Reset mid-operation: immediate abort to the reset values.
- hi_out/lo_out change only in DONE and hold between operations.

Decomposition:
- Opcode encodings (MULT/MULTU/DIV/DIVU) and the state encodings go in the shared `define.v` macros, beside `RegDataWidth.
- One natural sub-module: muldiv_datapath. It holds the shift registers and adder/subtractor and performs one iteration per enable. The FSM and sign handling stay in ex_muldiv.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF → after 33 stall cycles, done=1 with hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFE(-2) * 0x00000003 → hi=0xFFFFFFFF, lo=0xFFFFFFFA. stall_req is high for exactly 33 cycles, then drops in the DONE cycle.
- DIV 0xFFFFFFF9(-7) / 2 → lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIVU 100/7 → lo=14, hi=2.
- DIVU 5/0 → done one cycle after acceptance, div_by_zero=1, lo=0xFFFFFFFF, hi=5, only 1 stall cycle.
- Start DIV, assert flush at CALC iteration 10 → IDLE next edge, no done, hi/lo retain prior values. Then assert rst mid-CALC → all outputs 0 immediately.
- start held high across DONE with same operands → exactly one done pulse; a back-to-back new start in the following IDLE cycle is accepted.
